// File: rtl/clk_freq_meter_pkg.sv
// Shared types and default constants for the clock-frequency monitor.
package clk_freq_meter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_e;

    localparam int unsigned SYS_CLK_HZ     = 50_000_000;
    localparam int unsigned TICK_HZ        = 1_000;
    localparam int unsigned EXP_PERIOD_DEF = SYS_CLK_HZ / TICK_HZ;
    localparam int unsigned TOL_DEF        = 50;
    localparam int unsigned LOCK_N_DEF     = 4;
    localparam int unsigned TIMEOUT_DEF    = 2 * EXP_PERIOD_DEF;
    localparam int unsigned CNT_W_DEF      = 20;

endpackage

// File: rtl/clk_freq_meter_sync_edge_det.sv
// Two-flop synchroniser followed by a rising-edge detector on the synchronised signal.
module clk_freq_meter_sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_c_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Synchroniser chain plus one delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_c_o = s2_q & ~s3_q;

endmodule

// File: rtl/clk_freq_meter.sv
// Measures the period of a slow input in clk cycles, tracks tolerance lock and flags stalls.
module clk_freq_meter
    import clk_freq_meter_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned EXP_PERIOD = EXP_PERIOD_DEF,
    parameter int unsigned TOL        = TOL_DEF,
    parameter int unsigned LOCK_N     = LOCK_N_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int unsigned GOOD_W = $clog2(LOCK_N + 1);
    localparam logic [CNT_W:0] P_MIN = (CNT_W+1)'(EXP_PERIOD - TOL);
    localparam logic [CNT_W:0] P_MAX = (CNT_W+1)'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               pv_q, pv_d;
    logic               locked_q, locked_d;
    logic               to_q, to_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [GOOD_W-1:0]  good_inc_c;
    logic [CNT_W:0]     p_c;
    logic               in_tol_c;
    logic               rise_c;

    clk_freq_meter_sync_edge_det u_sync (
        .clk      (clk),
        .rst      (rst),
        .sig_i    (sig_in),
        .rise_c_o (rise_c)
    );

    // Candidate period (one wider than the counter) and its tolerance window check.
    assign p_c        = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign in_tol_c   = (p_c >= P_MIN) && (p_c <= P_MAX);
    assign good_inc_c = (good_q == GOOD_W'(LOCK_N)) ? good_q : good_q + GOOD_W'(1);

    // State, counter, lock and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            locked_q <= 1'b0;
            to_q     <= 1'b0;
            good_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            locked_q <= locked_d;
            to_q     <= to_d;
            good_q   <= good_d;
        end
    end

    // Next-state: start marker in IDLE, period capture / stall detection in MEAS.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        pv_d     = 1'b0;
        to_d     = 1'b0;
        locked_d = locked_q;
        good_d   = good_q;

        if (!en) begin
            state_d  = IDLE;
            cnt_d    = '0;
            good_d   = '0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (rise_c) begin
                        state_d = MEAS;
                    end
                end
                MEAS: begin
                    if (rise_c) begin
                        period_d = p_c[CNT_W-1:0];
                        pv_d     = 1'b1;
                        cnt_d    = '0;
                        if (in_tol_c) begin
                            good_d   = good_inc_c;
                            locked_d = (good_inc_c == GOOD_W'(LOCK_N));
                        end else begin
                            good_d   = '0;
                            locked_d = 1'b0;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        to_d     = 1'b1;
                        locked_d = 1'b0;
                        good_d   = '0;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign period       = period_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign timeout      = to_q;

endmodule

// File: tb/tb_clk_freq_meter.sv
// Directed bench for clk_freq_meter using scaled-down parameters (expected 50, tol 5, timeout 100).
module tb_clk_freq_meter;

    localparam int unsigned CW  = 8;
    localparam int unsigned EXP = 50;
    localparam int unsigned TL  = 5;
    localparam int unsigned LN  = 4;
    localparam int unsigned TO  = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          sig_in;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          locked;
    logic          timeout;

    int n_vec   = 0;
    int n_err   = 0;
    int cyc     = 0;
    int pv_cnt  = 0;
    int pv_time = 0;
    int to_cnt  = 0;
    int to_time = 0;
    int since   = 0;
    int exp_pv  = 0;
    int exp_to  = 0;

    always #5 clk = ~clk;

    clk_freq_meter #(
        .CNT_W      (CW),
        .EXP_PERIOD (EXP),
        .TOL        (TL),
        .LOCK_N     (LN),
        .TIMEOUT    (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sig_in       (sig_in),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout)
    );

    // Pulse recorder, sampled just after each active edge.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (period_valid) begin
            pv_cnt  = pv_cnt + 1;
            pv_time = cyc;
        end
        if (timeout) begin
            to_cnt  = to_cnt + 1;
            to_time = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec = n_vec + 1;
        assert (obs === expv) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        since = since + n;
    endtask

    task automatic start_rise();
        @(negedge clk);
        sig_in = 1'b1;
        since  = 0;
    endtask

    // Next rise exactly p negedges after the previous one, roughly 50% duty.
    task automatic next_rise(input int p);
        while (since < p / 2) tick(1);
        sig_in = 1'b0;
        while (since < p) tick(1);
        sig_in = 1'b1;
        since  = 0;
    endtask

    task automatic period_step(input int p, input int exp_lock);
        next_rise(p);
        tick(5);
        exp_pv = exp_pv + 1;
        chk("pv_count", 32'(pv_cnt), 32'(exp_pv));
        chk("period", 32'(period), 32'(p));
        chk("locked", 32'(locked), 32'(exp_lock));
        chk("timeout_count", 32'(to_cnt), 32'(exp_to));
    endtask

    task automatic go_low(input int at);
        while (since < at) tick(1);
        sig_in = 1'b0;
        tick(5);
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_period", 32'(period), 0);
        chk("rst_pv", 32'(period_valid), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_timeout", 32'(timeout), 0);
        rst = 1'b0;
        en  = 1'b1;
        tick(3);

        // First rise is only a start marker.
        start_rise();
        tick(5);
        chk("start_marker", 32'(pv_cnt), 0);

        // Lock on the 4th in-tolerance period.
        period_step(52, 0);
        period_step(52, 0);
        period_step(52, 0);
        period_step(52, 1);

        // Tolerance boundaries: 45 and 55 inside, 44 and 56 outside.
        period_step(55, 1);
        period_step(45, 1);
        period_step(56, 0);
        period_step(44, 0);

        // Relock, drop on one bad period, relock again.
        period_step(52, 0);
        period_step(52, 0);
        period_step(52, 0);
        period_step(52, 1);
        period_step(60, 0);
        period_step(52, 0);
        period_step(52, 0);
        period_step(52, 0);
        period_step(52, 1);

        // Stall: timeout exactly TO cycles after last captured rise.
        go_low(26);
        tick(TO + 10);
        exp_to = 1;
        chk("timeout_count", 32'(to_cnt), 1);
        chk("timeout_latency", 32'(to_time - pv_time), 32'(TO));
        chk("locked_after_stall", 32'(locked), 0);
        chk("pv_after_stall", 32'(pv_cnt), 32'(exp_pv));

        // Rise after stall is a start marker; rise on the last count wins over timeout.
        start_rise();
        tick(5);
        chk("restart_marker", 32'(pv_cnt), 32'(exp_pv));
        period_step(100, 0);

        // Reset in mid-period after locking.
        period_step(52, 0);
        period_step(52, 0);
        period_step(52, 0);
        period_step(52, 1);
        go_low(30);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_period", 32'(period), 0);
        chk("midrst_locked", 32'(locked), 0);
        chk("midrst_pv", 32'(period_valid), 0);
        chk("midrst_timeout", 32'(timeout), 0);
        rst = 1'b0;
        tick(3);
        start_rise();
        tick(5);
        chk("rst_marker", 32'(pv_cnt), 32'(exp_pv));
        period_step(52, 0);
        period_step(52, 0);
        period_step(52, 0);
        period_step(52, 1);

        // Enable drop in mid-period: lock clears, period holds.
        go_low(30);
        en = 1'b0;
        @(negedge clk);
        chk("en_locked", 32'(locked), 0);
        chk("en_period_hold", 32'(period), 52);
        chk("en_pv", 32'(period_valid), 0);
        chk("en_timeout", 32'(timeout), 0);
        en = 1'b1;
        tick(3);
        start_rise();
        tick(5);
        chk("en_marker", 32'(pv_cnt), 32'(exp_pv));
        period_step(52, 0);
        chk("final_timeout_count", 32'(to_cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
